// File: rtl/pixel_fetch_pkg.sv
// pixel_fetch_pkg: pixel types, frame constants, RGB565->RGB888 expansion and
// colour-bar table shared by the pixel_fetch slice.
package pixel_fetch_pkg;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    localparam int unsigned FRAME_PIXELS = 640 * 480;

    // Replicating the top bits maps full-scale 565 codes onto full-scale 888.
    function automatic rgb888_t expand565(input rgb565_t p);
        rgb888_t o;
        o.r = {p.r, p.r[4:2]};
        o.g = {p.g, p.g[5:4]};
        o.b = {p.b, p.b[4:2]};
        return o;
    endfunction

    function automatic rgb888_t bar_colour(input logic [2:0] idx);
        rgb888_t o;
        case (idx)
            3'd0:    o = {8'hFF, 8'hFF, 8'hFF};
            3'd1:    o = {8'hFF, 8'hFF, 8'h00};
            3'd2:    o = {8'h00, 8'hFF, 8'hFF};
            3'd3:    o = {8'h00, 8'hFF, 8'h00};
            3'd4:    o = {8'hFF, 8'h00, 8'hFF};
            3'd5:    o = {8'hFF, 8'h00, 8'h00};
            3'd6:    o = {8'h00, 8'h00, 8'hFF};
            default: o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/pixel_fetch_fifo.sv
// pix_sync_fifo: single-clock pixel FIFO with synchronous flush, head-of-queue
// output from registered storage, and occupancy level.
module pix_sync_fifo
    import pixel_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_full;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~w_full | w_do_pop);
    assign o_head    = r_mem[r_rd_ptr];
    assign o_level   = r_count;

    always_ff @(posedge i_clk) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
        end
    end

    // The upstream issue rule reserves a slot for every outstanding read.
    a_no_push_full: assert property (@(posedge i_clk) disable iff (i_rst || i_flush)
        !(i_push && w_full && !i_pop));

endmodule

// File: rtl/pixel_fetch.sv
// pixel_fetch: prefetches RGB565 pixels from frame memory into a FIFO and
// presents RGB888 one cycle after pix_req. PIXEL_FETCH_TEST_PATTERN_EN adds colour bars.
module pixel_fetch
    import pixel_fetch_pkg::*;
#(
    parameter int unsigned       FIFO_DEPTH = 16,
    parameter int unsigned       ADDR_W     = 26,
    parameter int unsigned       H_ACTIVE   = 640,
    parameter int unsigned       V_ACTIVE   = 480,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
    input  logic                          clk_low,
    input  logic                          reset,
    input  logic                          frame_start,
    input  logic                          pix_req,
`ifdef PIXEL_FETCH_TEST_PATTERN_EN
    input  logic                          pattern_en,
`endif
    output logic                          mem_rd,
    output logic [ADDR_W-1:0]             mem_addr,
    input  logic                          mem_ready,
    input  logic                          mem_rvalid,
    input  logic [15:0]                   mem_rdata,
    output logic [7:0]                    red,
    output logic [7:0]                    green,
    output logic [7:0]                    blue,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underflow
);

    localparam int unsigned LVL_W     = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned FRAME_CNT = H_ACTIVE * V_ACTIVE;
    localparam int unsigned ISS_W     = $clog2(FRAME_CNT + 1);
    localparam int unsigned DROP_W    = LVL_W + 2;

    logic              r_mem_rd;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [ISS_W-1:0]  r_issued;
    logic [LVL_W-1:0]  r_outstanding;
    logic [DROP_W-1:0] r_drop;
    logic              r_underflow;
    rgb888_t           r_rgb;

    logic              w_accept;
    logic              w_ret;
    logic              w_drop_word;
    logic              w_push;
    logic              w_pop;
    logic              w_empty;
    logic [15:0]       w_head;
    logic [LVL_W-1:0]  w_level;
    logic [LVL_W-1:0]  w_lvl_next;
    logic [LVL_W-1:0]  w_out_next;
    logic [ISS_W-1:0]  w_iss_next;
    logic              w_room;
    logic              w_issue;
    logic [DROP_W-1:0] w_drop_flush;
    rgb888_t           w_pix;

    assign w_accept    = r_mem_rd & mem_ready;
    assign w_ret       = mem_rvalid & (r_drop == '0);
    assign w_drop_word = mem_rvalid & (r_drop != '0);
    assign w_push      = w_ret & ~frame_start;
    assign w_pop       = pix_req & ~w_empty & ~frame_start;

    pix_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .i_clk   (clk_low),
        .i_rst   (reset),
        .i_flush (frame_start),
        .i_push  (w_push),
        .i_wdata (mem_rdata),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_level (w_level),
        .o_empty (w_empty)
    );

    // mem_rd is registered, so the issue decision looks at next-cycle occupancy.
    assign w_lvl_next = w_level + LVL_W'(w_push) - LVL_W'(w_pop);
    assign w_out_next = r_outstanding + LVL_W'(w_accept) - LVL_W'(w_ret);
    assign w_iss_next = r_issued + ISS_W'(w_accept);
    assign w_room     = ({1'b0, w_lvl_next} + {1'b0, w_out_next}) < (LVL_W+1)'(FIFO_DEPTH);
    assign w_issue    = w_room & (w_iss_next < ISS_W'(FRAME_CNT));

    // Everything still in flight at a restart is discarded: old drops, outstanding
    // reads and a same-cycle accept, minus the word returning right now.
    assign w_drop_flush = r_drop + DROP_W'(r_outstanding) + DROP_W'(w_accept)
                          - DROP_W'(mem_rvalid);

    always_ff @(posedge clk_low or posedge reset) begin
        if (reset) begin
            r_mem_rd      <= 1'b0;
            r_mem_addr    <= BASE_ADDR;
            r_issued      <= '0;
            r_outstanding <= '0;
            r_drop        <= '0;
            r_underflow   <= 1'b0;
        end else if (frame_start) begin
            r_mem_rd      <= 1'b0;
            r_mem_addr    <= BASE_ADDR;
            r_issued      <= '0;
            r_outstanding <= '0;
            r_drop        <= w_drop_flush;
            r_underflow   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_mem_addr <= r_mem_addr + ADDR_W'(1);
            end
            r_issued      <= w_iss_next;
            r_outstanding <= w_out_next;
            r_drop        <= r_drop - DROP_W'(w_drop_word);
            r_mem_rd      <= (r_mem_rd & ~w_accept) | w_issue;
            if (pix_req && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

`ifdef PIXEL_FETCH_TEST_PATTERN_EN
    localparam int unsigned COL_W = $clog2(H_ACTIVE);
    localparam int unsigned BAR_W = H_ACTIVE / 8;

    logic [COL_W-1:0] r_col;
    logic [2:0]       w_bar;

    always_ff @(posedge clk_low or posedge reset) begin
        if (reset) begin
            r_col <= '0;
        end else if (frame_start) begin
            r_col <= '0;
        end else if (pix_req) begin
            r_col <= (r_col == COL_W'(H_ACTIVE - 1)) ? '0 : r_col + COL_W'(1);
        end
    end

    assign w_bar = 3'(r_col / COL_W'(BAR_W));
    assign w_pix = pattern_en ? bar_colour(w_bar) : expand565(rgb565_t'(w_head));
`else
    assign w_pix = expand565(rgb565_t'(w_head));
`endif

    // An empty FIFO yields black even if a word lands the same cycle.
    always_ff @(posedge clk_low or posedge reset) begin
        if (reset) begin
            r_rgb <= '0;
        end else if (!frame_start && pix_req) begin
            r_rgb <= w_empty ? '0 : w_pix;
        end
    end

    assign mem_rd     = r_mem_rd;
    assign mem_addr   = r_mem_addr;
    assign red        = r_rgb.r;
    assign green      = r_rgb.g;
    assign blue       = r_rgb.b;
    assign fifo_level = w_level;
    assign underflow  = r_underflow;

endmodule
